alu_mc: RTL

- Parametrised-width successor to the 32-bit ripple ALU in the EX stage of the 5-stage pipeline.
- Keeps the single-cycle AND/OR/ADD/SUB/SLT set.
- Adds multi-cycle unsigned multiply (shift-add) and unsigned divide (restoring), with a valid/ready handshake.
- Registers all results. The pipeline stalls the EX stage while busy is high.

---
 rtl/alu_mc.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : EX-stage ALU with registered single-cycle ops and multi-cycle
//               shift-add MULTU / restoring DIVU behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH      = 32,
  parameter bit SLT_SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             div_zero,
  output logic             busy
);

  localparam int         c_cw       = $clog2(WIDTH + 1);
  localparam logic [2:0] c_op_and   = 3'b000;
  localparam logic [2:0] c_op_or    = 3'b001;
  localparam logic [2:0] c_op_add   = 3'b010;
  localparam logic [2:0] c_op_multu = 3'b011;
  localparam logic [2:0] c_op_divu  = 3'b100;
  localparam logic [2:0] c_op_sub   = 3'b110;
  localparam logic [2:0] c_op_slt   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_cw-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_acc_hi;
  logic [WIDTH-1:0]  r_acc_lo;
  logic [WIDTH-1:0]  r_opb;
  logic              r_div_zero_pend;

  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  r_hi;
  logic              r_c_out;
  logic              r_overflow;
  logic              r_zero;
  logic              r_div_zero;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_div;

  // Shared adder for ADD, SUB and SLT
  logic              w_sub;
  logic [WIDTH-1:0]  w_b_eff;
  logic [WIDTH:0]    w_sum_full;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;
  logic              w_c_msb;
  logic              w_ovf;
  logic              w_slt_set;
  logic [WIDTH-1:0]  w_alu_res;
  logic              w_alu_c;
  logic              w_alu_v;

  logic [WIDTH:0]    w_mul_add;
  logic [WIDTH+1:0]  w_div_full;
  logic              w_div_ok;
  logic [WIDTH-1:0]  w_step_hi;
  logic [WIDTH-1:0]  w_step_lo;

  assign in_ready  = (r_state == S_IDLE) && reset;
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = (sel == c_op_multu);
  assign w_is_div  = (sel == c_op_divu);

  assign w_sub      = (sel == c_op_sub) || (sel == c_op_slt);
  assign w_b_eff    = w_sub ? ~b : b;
  assign w_sum_full = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
  assign w_sum      = w_sum_full[WIDTH-1:0];
  assign w_cout     = w_sum_full[WIDTH];
  assign w_c_msb    = a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];
  assign w_ovf      = w_c_msb ^ w_cout;
  assign w_slt_set  = SLT_SIGNED ? (w_sum[WIDTH-1] ^ w_ovf) : ~w_cout;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (sel)
      c_op_and: w_alu_res = a & b;
      c_op_or:  w_alu_res = a | b;
      c_op_add, c_op_sub: begin
        w_alu_res = w_sum;
        w_alu_c   = w_cout;
        w_alu_v   = w_ovf;
      end
      c_op_slt: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt_set};
      default:  w_alu_res = '0;
    endcase
  end

  // Multiply step: conditional add into the high half, then shift {carry, hi, lo} right
  assign w_mul_add = {1'b0, r_acc_hi} + ({1'b0, r_opb} & {(WIDTH+1){r_acc_lo[0]}});

  // Divide step: trial-subtract from the left-shifted remainder. A successful
  // trial can never leave bit WIDTH set, so both upper bits must be clear.
  assign w_div_full = {1'b0, r_acc_hi, r_acc_lo[WIDTH-1]} - {2'b00, r_opb};
  assign w_div_ok   = (w_div_full[WIDTH+1:WIDTH] == 2'b00);

  always_comb begin
    w_step_hi = w_mul_add[WIDTH:1];
    w_step_lo = {w_mul_add[0], r_acc_lo[WIDTH-1:1]};
    if (r_state == S_DIV) begin
      w_step_hi = w_div_ok ? w_div_full[WIDTH-1:0]
                           : {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
      w_step_lo = {r_acc_lo[WIDTH-2:0], w_div_ok};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
        else if (w_accept && w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (r_cnt == c_cw'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt           <= '0;
      r_acc_hi        <= '0;
      r_acc_lo        <= '0;
      r_opb           <= '0;
      r_div_zero_pend <= 1'b0;
      r_result        <= '0;
      r_hi            <= '0;
      r_c_out         <= 1'b0;
      r_overflow      <= 1'b0;
      r_zero          <= 1'b0;
      r_div_zero      <= 1'b0;
      r_out_valid     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul || w_is_div) begin
              r_cnt           <= c_cw'(WIDTH);
              r_acc_hi        <= '0;
              r_acc_lo        <= a;
              r_opb           <= b;
              r_div_zero_pend <= w_is_div && (b == '0);
            end else begin
              r_result    <= w_alu_res;
              r_hi        <= '0;
              r_c_out     <= w_alu_c;
              r_overflow  <= w_alu_v;
              r_zero      <= (w_alu_res == '0);
              r_div_zero  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_cnt    <= r_cnt - c_cw'(1);
          // Publish on the final iteration so out_valid coincides with DONE
          if (r_cnt == c_cw'(1)) begin
            r_result    <= w_step_lo;
            r_hi        <= w_step_hi;
            r_c_out     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= (w_step_lo == '0);
            r_div_zero  <= r_div_zero_pend;
            r_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign hi        = r_hi;
  assign c_out     = r_c_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign div_zero  = r_div_zero;

endmodule
`default_nettype wire
